// File: rtl/snake_game_ctrl_if.sv
// Sequencer <-> playfield link: command pulses, direction and the probe read port.
// start/step are single-cycle strobes with no back-pressure; cell_val is a same-cycle read of cell_idx.
interface snake_game_ctrl_if #(
    parameter int CELLBITS = 7
);
    logic                start;
    logic                step;
    logic [1:0]          snake_dir;
    logic [CELLBITS-1:0] cell_idx;
    logic [2:0]          cell_val;

    modport master (
        output start,
        output step,
        output snake_dir,
        output cell_idx,
        input  cell_val
    );

    modport slave (
        input  start,
        input  step,
        input  snake_dir,
        input  cell_idx,
        output cell_val
    );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: paces moves, tracks a shadow head, probes the cell ahead,
// ends the game on wall/body hits and keeps a saturating apple score.
module snake_game_ctrl #(
    parameter logic [7:0]  SIZE_X   = 8'd10,
    parameter logic [7:0]  SIZE_Y   = 8'd10,
    parameter logic [23:0] TICK_DIV = 24'd5_000_000,
    parameter int          SCORE_W  = 8,
    parameter int          CELLBITS = $clog2(int'(SIZE_X) * int'(SIZE_Y))
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic [3:0]         btn_dir,
    snake_game_ctrl_if.master  fld,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_PAUSE = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    state_t              st, st_n;
    logic [23:0]         tick, tick_n;
    logic [7:0]          hx, hx_n, hy, hy_n;
    logic [1:0]          mv_dir, mv_dir_n;
    logic [1:0]          dir_r, dir_n;
    logic [SCORE_W-1:0]  score_r, score_n;
    logic                start_r, start_n;
    logic                step_r, step_n;

    logic [7:0]          nx, ny;
    logic                wall_hit, body_hit, apple;
    logic [1:0]          req;
    logic                req_ok;

    // Wall is judged from the current head so an edge cell never wraps into a false in-range probe.
    always_comb begin
        nx       = hx;
        ny       = hy;
        wall_hit = 1'b0;
        case (mv_dir)
            2'd0: begin
                ny       = hy - 8'd1;
                wall_hit = (hy == 8'd0);
            end
            2'd1: begin
                nx       = hx + 8'd1;
                wall_hit = (hx == SIZE_X - 8'd1);
            end
            2'd2: begin
                ny       = hy + 8'd1;
                wall_hit = (hy == SIZE_Y - 8'd1);
            end
            default: begin
                nx       = hx - 8'd1;
                wall_hit = (hx == 8'd0);
            end
        endcase
    end

    assign fld.cell_idx = CELLBITS'(ny) * CELLBITS'(SIZE_X) + CELLBITS'(nx);
    assign body_hit     = (fld.cell_val != 3'd0) && (fld.cell_val <= 3'd4);
    assign apple        = (fld.cell_val == 3'd5);

    always_comb begin
        req = 2'd3;
        if (btn_dir[0])      req = 2'd0;
        else if (btn_dir[1]) req = 2'd1;
        else if (btn_dir[2]) req = 2'd2;
    end

    // Reversal is checked against the direction the field will actually move next.
    assign req_ok = (btn_dir != 4'd0) && ((req ^ mv_dir) != 2'd2);

    always_comb begin
        st_n     = st;
        tick_n   = tick;
        hx_n     = hx;
        hy_n     = hy;
        mv_dir_n = mv_dir;
        dir_n    = dir_r;
        score_n  = score_r;
        start_n  = 1'b0;
        step_n   = 1'b0;
        if (btn_start) begin
            st_n = ST_INIT;
        end else begin
            if (req_ok && (st == ST_RUN || st == ST_CHECK || st == ST_PAUSE)) begin
                dir_n = req;
            end
            case (st)
                ST_IDLE: st_n = ST_IDLE;
                ST_INIT: begin
                    start_n  = 1'b1;
                    hx_n     = 8'd4;
                    hy_n     = 8'd1;
                    mv_dir_n = 2'd1;
                    dir_n    = 2'd1;
                    score_n  = '0;
                    tick_n   = '0;
                    st_n     = ST_RUN;
                end
                ST_RUN: begin
                    if (btn_pause) begin
                        st_n = ST_PAUSE;
                    end else if (tick == TICK_DIV - 24'd1) begin
                        tick_n = '0;
                        st_n   = ST_CHECK;
                    end else begin
                        tick_n = tick + 24'd1;
                    end
                end
                ST_CHECK: begin
                    if (wall_hit || body_hit) begin
                        st_n = ST_OVER;
                    end else begin
                        step_n   = 1'b1;
                        hx_n     = nx;
                        hy_n     = ny;
                        mv_dir_n = dir_r;
                        if (apple && (score_r != {SCORE_W{1'b1}})) begin
                            score_n = score_r + SCORE_W'(1);
                        end
                        st_n = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (btn_pause) st_n = ST_RUN;
                end
                ST_OVER: st_n = ST_OVER;
                default: st_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= ST_IDLE;
            tick    <= '0;
            hx      <= 8'd0;
            hy      <= 8'd0;
            mv_dir  <= 2'd1;
            dir_r   <= 2'd1;
            score_r <= '0;
            start_r <= 1'b0;
            step_r  <= 1'b0;
        end else begin
            st      <= st_n;
            tick    <= tick_n;
            hx      <= hx_n;
            hy      <= hy_n;
            mv_dir  <= mv_dir_n;
            dir_r   <= dir_n;
            score_r <= score_n;
            start_r <= start_n;
            step_r  <= step_n;
        end
    end

    assign fld.start     = start_r;
    assign fld.step      = step_r;
    assign fld.snake_dir = dir_r;
    assign score         = score_r;
    assign game_over     = (st == ST_OVER);
    assign state         = st;

endmodule
